// File: rtl/rtc_bcd_clock_pkg.sv
// Shared types, limits and the BCD legality helper for the BCD real-time clock.
package rtc_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   typedef enum logic {
      IDLE,
      COMMIT
   } load_state_t;

   localparam int MAX_HH = 23;
   localparam int MAX_MS = 59;

   // Both digits must be decimal before the numeric range test means anything.
   function automatic logic bcd2_legal(input bcd2_t value, input int max);
      int v;
      v = int'(value.tens) * 10 + int'(value.ones);
      return (value.tens <= 4'd9) && (value.ones <= 4'd9) && (v <= max);
   endfunction

endpackage

// File: rtl/rtc_bcd_clock_if.sv
// Load handshake between a time source (master) and the RTC (slave).
interface rtc_bcd_clock_if;
   import rtc_pkg::*;

   logic  load_valid;
   logic  load_ready;
   logic  load_err;
   bcd2_t load_hh;
   bcd2_t load_mm;
   bcd2_t load_ss;

   modport master (
      output load_valid, load_hh, load_mm, load_ss,
      input  load_ready, load_err
   );

   modport slave (
      input  load_valid, load_hh, load_mm, load_ss,
      output load_ready, load_err
   );

endinterface

// File: rtl/rtc_bcd_digit_pair.sv
// Two-digit BCD counter modulo N with synchronous load and a carry on wrap.
module rtc_bcd_digit_pair
   import rtc_pkg::*;
#(
   parameter int N = 60
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  inc,
   input  logic  load,
   input  bcd2_t load_val,
   output bcd2_t value,
   output logic  carry_out
);

   localparam bcd_t MAX_TENS = bcd_t'((N - 1) / 10);
   localparam bcd_t MAX_ONES = bcd_t'((N - 1) % 10);

   logic at_max;

   assign at_max    = (value.tens == MAX_TENS) && (value.ones == MAX_ONES);
   assign carry_out = inc && at_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         if (at_max) begin
            value <= '0;
         end else if (value.ones == 4'd9) begin
            value.tens <= value.tens + 4'd1;
            value.ones <= 4'd0;
         end else begin
            value.ones <= value.ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD HH:MM:SS real-time clock with prescaler, validated load and 12h/24h display.
// Define RTC_ALARM_EN to add the hh:mm alarm compare and its ports.
module rtc_bcd_clock
   import rtc_pkg::*;
#(
   parameter  int CLK_HZ = 50_000_000,
   localparam int PRE_W  = $clog2(CLK_HZ)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              hour12,
   rtc_bcd_clock_if.slave    load_bus,
   output logic [7:0]        hh_o,
   output logic [7:0]        mm_o,
   output logic [7:0]        ss_o,
   output logic              pm_o,
   output logic              sec_tick,
   output logic              min_tick,
   output logic              day_tick
`ifdef RTC_ALARM_EN
   ,
   input  logic              alarm_arm,
   input  logic [7:0]        alarm_hh,
   input  logic [7:0]        alarm_mm,
   output logic              alarm_hit
`endif
);

   load_state_t      state;
   logic [PRE_W-1:0] pre;
   bcd2_t            cap_hh, cap_mm, cap_ss;
   logic             cap_legal;
   bcd2_t            hh, mm, ss;
   logic             ss_carry, mm_carry, hh_carry;
   logic             accept, in_legal, commit_legal, pre_wrap, advance;
   logic [4:0]       hour_bin, hour_disp;

   assign accept       = load_bus.load_valid && load_bus.load_ready;
   assign in_legal     = bcd2_legal(load_bus.load_hh, MAX_HH) &&
                         bcd2_legal(load_bus.load_mm, MAX_MS) &&
                         bcd2_legal(load_bus.load_ss, MAX_MS);
   assign commit_legal = (state == COMMIT) && cap_legal;
   assign pre_wrap     = en && (pre == PRE_W'(CLK_HZ - 1));

   // A legal load in flight overrides the second that would land at the same time.
   assign advance      = pre_wrap && !commit_legal && !(accept && in_legal);

   // Legality is judged at accept so the error pulse lines up with the commit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         load_bus.load_ready <= 1'b0;
         load_bus.load_err   <= 1'b0;
         cap_hh              <= '0;
         cap_mm              <= '0;
         cap_ss              <= '0;
         cap_legal           <= 1'b0;
      end else begin
         load_bus.load_err <= accept && !in_legal;
         case (state)
            IDLE: begin
               if (accept) begin
                  state               <= COMMIT;
                  load_bus.load_ready <= 1'b0;
                  cap_hh              <= load_bus.load_hh;
                  cap_mm              <= load_bus.load_mm;
                  cap_ss              <= load_bus.load_ss;
                  cap_legal           <= in_legal;
               end else begin
                  load_bus.load_ready <= 1'b1;
               end
            end
            COMMIT: begin
               state               <= IDLE;
               load_bus.load_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre      <= '0;
         sec_tick <= 1'b0;
         min_tick <= 1'b0;
         day_tick <= 1'b0;
      end else begin
         if (commit_legal || pre_wrap) begin
            pre <= '0;
         end else if (en) begin
            pre <= pre + 1'b1;
         end
         sec_tick <= advance;
         min_tick <= ss_carry;
         day_tick <= hh_carry;
      end
   end

   rtc_bcd_digit_pair #(.N(60)) ss_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (advance),
      .load      (commit_legal),
      .load_val  (cap_ss),
      .value     (ss),
      .carry_out (ss_carry)
   );

   rtc_bcd_digit_pair #(.N(60)) mm_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (ss_carry),
      .load      (commit_legal),
      .load_val  (cap_mm),
      .value     (mm),
      .carry_out (mm_carry)
   );

   rtc_bcd_digit_pair #(.N(24)) hh_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (mm_carry),
      .load      (commit_legal),
      .load_val  (cap_hh),
      .value     (hh),
      .carry_out (hh_carry)
   );

   // Midnight and noon both read 12 on a 12h face; only pm_o tells them apart.
   always_comb begin
      hour_bin  = 5'(hh.tens) * 5'd10 + 5'(hh.ones);
      pm_o      = (hour_bin >= 5'd12);
      hour_disp = hour_bin;
      if (hour_bin == 5'd0) begin
         hour_disp = 5'd12;
      end else if (hour_bin > 5'd12) begin
         hour_disp = hour_bin - 5'd12;
      end
      if (!hour12) begin
         hh_o = hh;
      end else if (hour_disp >= 5'd10) begin
         hh_o = {4'd1, 4'(hour_disp - 5'd10)};
      end else begin
         hh_o = {4'd0, 4'(hour_disp)};
      end
      mm_o = mm;
      ss_o = ss;
   end

`ifdef RTC_ALARM_EN
   assign alarm_hit = sec_tick && alarm_arm && (ss == 8'h00) &&
                      (hh == alarm_hh) && (mm == alarm_mm);
`endif

endmodule
